// File: rtl/pspin_her_arb_gen.sv
// Round-robin arbiter turning ingress DMA completions into handler execution requests (HERs).
// Optional per-context handshake counters are built when PSPIN_HER_GEN_STATS_EN is defined.
module pspin_her_arb_gen #(
    parameter int NUM_CHANNELS    = 2,
    parameter int NUM_HANDLER_CTX = 4,
    parameter int C_MSGID_WIDTH   = 10,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH       = 20,
    parameter int TAG_WIDTH       = 32,
    parameter int META_WIDTH      = 576,
    parameter int FIFO_DEPTH      = 4,
    localparam int CTX_W          = $clog2(NUM_HANDLER_CTX)
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [NUM_CHANNELS-1:0]                gen_valid,
    output logic [NUM_CHANNELS-1:0]                gen_ready,
    input  logic [NUM_CHANNELS*AXI_ADDR_WIDTH-1:0] gen_addr,
    input  logic [NUM_CHANNELS*LEN_WIDTH-1:0]      gen_len,
    input  logic [NUM_CHANNELS*TAG_WIDTH-1:0]      gen_tag,
    input  logic                                   conf_wr_en,
    input  logic [CTX_W-1:0]                       conf_wr_ctx,
    input  logic [META_WIDTH-1:0]                  conf_wr_meta,
    input  logic                                   conf_wr_enabled,
    input  logic [AXI_ADDR_WIDTH-1:0]              conf_xfer_limit,
    output logic                                   her_valid,
    input  logic                                   her_ready,
    output logic [C_MSGID_WIDTH-1:0]               her_msgid,
    output logic                                   her_is_eom,
    output logic [AXI_ADDR_WIDTH-1:0]              her_addr,
    output logic [AXI_ADDR_WIDTH-1:0]              her_size,
    output logic [AXI_ADDR_WIDTH-1:0]              her_xfer_size,
    output logic [META_WIDTH-1:0]                  her_meta,
    output logic [CTX_W-1:0]                       her_ctx_id,
    output logic [NUM_HANDLER_CTX*32-1:0]          stat_her_cnt,
    output logic [31:0]                            stat_fallback_cnt
);

    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_USED = CTX_W + 1 + C_MSGID_WIDTH;

    typedef struct packed {
        logic [META_WIDTH-1:0]     meta;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [AXI_ADDR_WIDTH-1:0] size;
        logic [AXI_ADDR_WIDTH-1:0] xfer;
        logic [C_MSGID_WIDTH-1:0]  msgid;
        logic                      eom;
        logic [CTX_W-1:0]          ctx;
        logic                      fallback;
    } her_t;

    function automatic logic [AXI_ADDR_WIDTH-1:0] clamp_xfer(
        input logic [AXI_ADDR_WIDTH-1:0] len,
        input logic [AXI_ADDR_WIDTH-1:0] limit
    );
        return ((limit != '0) && (limit < len)) ? limit : len;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Context table: writes land on the next edge, so lookups always see the _q copy.
    logic [META_WIDTH-1:0]      meta_q [NUM_HANDLER_CTX];
    logic [META_WIDTH-1:0]      meta_d [NUM_HANDLER_CTX];
    logic [NUM_HANDLER_CTX-1:0] en_q, en_d;

    always_comb begin
        meta_d = meta_q;
        en_d   = en_q;
        if (conf_wr_en) begin
            meta_d[conf_wr_ctx] = conf_wr_meta;
            en_d[conf_wr_ctx]   = conf_wr_enabled;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_HANDLER_CTX; k++) meta_q[k] <= '0;
            en_q <= '0;
        end else begin
            meta_q <= meta_d;
            en_q   <= en_d;
        end
    end

    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0] grant_idx;
    logic            grant_found;

    always_comb begin : arb_comb
        logic [CH_W-1:0] cand;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            cand = CH_W'((int'(rr_ptr_q) + i) % NUM_CHANNELS);
            if (!grant_found && gen_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             can_push, push, pop;

    // Full check uses the registered count only: a pop in the same cycle never frees a slot early.
    assign can_push = rstn && en_q[0] && (count_q < CNT_W'(FIFO_DEPTH));
    assign push     = grant_found && can_push;
    assign her_valid = rstn && (count_q != '0);
    assign pop      = her_valid && her_ready;

    always_comb begin
        gen_ready = '0;
        if (push) gen_ready[grant_idx] = 1'b1;
    end

    logic [TAG_WIDTH-1:0]      sel_tag;
    logic [AXI_ADDR_WIDTH-1:0] sel_len;
    logic [CTX_W-1:0]          tag_ctx;
    her_t                      new_her;

    always_comb begin
        sel_tag  = gen_tag[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH];
        sel_len  = AXI_ADDR_WIDTH'(gen_len[int'(grant_idx)*LEN_WIDTH +: LEN_WIDTH]);
        tag_ctx  = sel_tag[CTX_W-1:0];
        new_her.fallback = !en_q[tag_ctx];
        new_her.ctx      = new_her.fallback ? '0 : tag_ctx;
        new_her.meta     = meta_q[new_her.ctx];
        new_her.eom      = sel_tag[CTX_W];
        new_her.msgid    = sel_tag[CTX_W+1 +: C_MSGID_WIDTH];
        new_her.addr     = gen_addr[int'(grant_idx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        new_her.size     = sel_len;
        new_her.xfer     = clamp_xfer(sel_len, conf_xfer_limit);
    end

    generate
        if (TAG_WIDTH > TAG_USED) begin : g_tag_hi
            logic unused_tag_hi;
            assign unused_tag_hi = ^sel_tag[TAG_WIDTH-1:TAG_USED];
        end
    endgenerate

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (grant_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    her_t fifo_q [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= new_her;
    end

    her_t head;
    assign head          = fifo_q[rd_ptr_q];
    assign her_msgid     = head.msgid;
    assign her_is_eom    = head.eom;
    assign her_addr      = head.addr;
    assign her_size      = head.size;
    assign her_xfer_size = head.xfer;
    assign her_meta      = head.meta;
    assign her_ctx_id    = head.ctx;

`ifdef PSPIN_HER_GEN_STATS_EN
    logic [31:0] her_cnt_q [NUM_HANDLER_CTX];
    logic [31:0] her_cnt_d [NUM_HANDLER_CTX];
    logic [31:0] fb_cnt_q, fb_cnt_d;

    always_comb begin
        her_cnt_d = her_cnt_q;
        fb_cnt_d  = fb_cnt_q;
        if (pop) begin
            her_cnt_d[head.ctx] = sat_inc(her_cnt_q[head.ctx]);
            if (head.fallback) fb_cnt_d = sat_inc(fb_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_HANDLER_CTX; k++) her_cnt_q[k] <= '0;
            fb_cnt_q <= '0;
        end else begin
            her_cnt_q <= her_cnt_d;
            fb_cnt_q  <= fb_cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_HANDLER_CTX; k++) begin : g_stat
        assign stat_her_cnt[k*32 +: 32] = her_cnt_q[k];
    end
    assign stat_fallback_cnt = fb_cnt_q;
`else
    logic unused_fallback;
    assign unused_fallback   = head.fallback;
    assign stat_her_cnt      = '0;
    assign stat_fallback_cnt = '0;
`endif

endmodule

// File: tb/tb_pspin_her_arb_gen.sv
// Directed bench for pspin_her_arb_gen: vector table for single HERs plus hand sequences
// for round-robin, full FIFO, write-cycle lookup, context-0 disable and mid-run reset.
module tb_pspin_her_arb_gen;

    localparam int N    = 2;
    localparam int NCTX = 4;
    localparam int AW   = 32;
    localparam int LW   = 20;
    localparam int TW   = 32;
    localparam int MW   = 576;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    gen_valid;
    logic [N-1:0]    gen_ready;
    logic [N*AW-1:0] gen_addr;
    logic [N*LW-1:0] gen_len;
    logic [N*TW-1:0] gen_tag;
    logic            conf_wr_en;
    logic [1:0]      conf_wr_ctx;
    logic [MW-1:0]   conf_wr_meta;
    logic            conf_wr_enabled;
    logic [AW-1:0]   conf_xfer_limit;
    logic            her_valid;
    logic            her_ready;
    logic [9:0]      her_msgid;
    logic            her_is_eom;
    logic [AW-1:0]   her_addr;
    logic [AW-1:0]   her_size;
    logic [AW-1:0]   her_xfer_size;
    logic [MW-1:0]   her_meta;
    logic [1:0]      her_ctx_id;
    logic [NCTX*32-1:0] stat_her_cnt;
    logic [31:0]     stat_fallback_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    pspin_her_arb_gen dut (
        .clk(clk), .rstn(rstn),
        .gen_valid(gen_valid), .gen_ready(gen_ready),
        .gen_addr(gen_addr), .gen_len(gen_len), .gen_tag(gen_tag),
        .conf_wr_en(conf_wr_en), .conf_wr_ctx(conf_wr_ctx), .conf_wr_meta(conf_wr_meta),
        .conf_wr_enabled(conf_wr_enabled), .conf_xfer_limit(conf_xfer_limit),
        .her_valid(her_valid), .her_ready(her_ready), .her_msgid(her_msgid),
        .her_is_eom(her_is_eom), .her_addr(her_addr), .her_size(her_size),
        .her_xfer_size(her_xfer_size), .her_meta(her_meta), .her_ctx_id(her_ctx_id),
        .stat_her_cnt(stat_her_cnt), .stat_fallback_cnt(stat_fallback_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  msgid;
        logic        eom;
        logic [1:0]  ctx;
        logic [19:0] len;
        logic [31:0] lim;
        logic [1:0]  exp_ctx;
        logic [31:0] exp_xfer;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [31:0] mk_tag(input logic [9:0] msgid, input logic eom, input logic [1:0] ctx);
        return {19'h5A5A5, msgid, eom, ctx};
    endfunction

    function automatic logic [MW-1:0] meta_of(input int k);
        logic [MW-1:0] m;
        for (int j = 0; j < MW/32; j++) m[j*32 +: 32] = 32'hA000_0000 + k;
        return m;
    endfunction

    task automatic drive_ch(input int ch, input logic [31:0] a, input logic [19:0] l, input logic [31:0] t);
        gen_addr[ch*AW +: AW] = a;
        gen_len[ch*LW +: LW]  = l;
        gen_tag[ch*TW +: TW]  = t;
    endtask

    task automatic conf(input int k, input logic en);
        conf_wr_en      = 1'b1;
        conf_wr_ctx     = 2'(k);
        conf_wr_meta    = meta_of(k);
        conf_wr_enabled = en;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  exp_gr [4];
        logic [9:0]  exp_msg [4];
        logic [31:0] exp_cnt [4];
        logic [31:0] exp_fb;

        vecs[0] = '{10'd5,     1'b1, 2'd1, 20'd64,     32'd0,          2'd1, 32'd64};
        vecs[1] = '{10'd7,     1'b0, 2'd3, 20'd100,    32'd0,          2'd0, 32'd100};
        vecs[2] = '{10'h3FF,   1'b1, 2'd2, 20'd1000,   32'd256,        2'd2, 32'd256};
        vecs[3] = '{10'd1,     1'b0, 2'd0, 20'd1000,   32'd0,          2'd0, 32'd1000};
        vecs[4] = '{10'd2,     1'b1, 2'd1, 20'd256,    32'd256,        2'd1, 32'd256};
        vecs[5] = '{10'd3,     1'b0, 2'd2, 20'hFFFFF,  32'hFFFF_FFFF,  2'd2, 32'hFFFFF};
        vecs[6] = '{10'h155,   1'b1, 2'd0, 20'd100,    32'd1,          2'd0, 32'd1};

        rstn = 1'b0; gen_valid = '0; gen_addr = '0; gen_len = '0; gen_tag = '0;
        conf_wr_en = 1'b0; conf_wr_ctx = '0; conf_wr_meta = '0; conf_wr_enabled = 1'b0;
        conf_xfer_limit = '0; her_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        gen_valid = 2'b11;
        mid();
        chk("rst_her_valid", her_valid, 0);
        chk("rst_gen_ready", gen_ready, 0);
        chk("rst_fallback_cnt", stat_fallback_cnt, 0);
        chk("rst_her_cnt", stat_her_cnt, 0);
        tick();
        rstn = 1'b1;
        mid();
        chk("ctx0_off_ready", gen_ready, 0);
        chk("idle_her_valid", her_valid, 0);
        tick();
        gen_valid = '0;

        // ctx0..2 enabled, ctx3 written but disabled; ctx0 enable is not visible in its write cycle
        for (int k = 0; k < NCTX; k++) begin
            conf(k, k != 3);
            if (k == 0) gen_valid = 2'b01;
            mid();
            if (k == 0) chk("wr_cycle_old_en", gen_ready, 0);
            tick();
            gen_valid = '0;
        end
        conf_wr_en = 1'b0;

        // Round-robin from reset pointer (channel 0) with both channels valid
        drive_ch(0, 32'h1000, 20'd16, mk_tag(10'h10, 1'b0, 2'd1));
        drive_ch(1, 32'h2000, 20'd32, mk_tag(10'h20, 1'b1, 2'd2));
        exp_gr  = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_msg = '{10'h0, 10'h10, 10'h20, 10'h10};
        her_ready = 1'b1;
        gen_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            mid();
            chk("rr_grant", gen_ready, exp_gr[c]);
            chk("rr_her_valid", her_valid, (c > 0) ? 1 : 0);
            if (c > 0) chk("rr_order", her_msgid, exp_msg[c]);
            tick();
        end
        gen_valid = '0;
        mid();
        chk("rr_last_msgid", her_msgid, 10'h20);
        chk("rr_last_addr", her_addr, 32'h2000);
        chk("rr_last_ctx", her_ctx_id, 2'd2);
        tick();
        her_ready = 1'b0;
        mid();
        chk("rr_drained", her_valid, 0);
        tick();

        for (int i = 0; i < 7; i++) begin
            conf_xfer_limit = vecs[i].lim;
            drive_ch(0, 32'h8000_0000 + 32'(i) * 32'h100, vecs[i].len,
                     mk_tag(vecs[i].msgid, vecs[i].eom, vecs[i].ctx));
            gen_valid = 2'b01;
            mid();
            chk("v_gen_ready", gen_ready, 2'b01);
            chk("v_empty_before", her_valid, 0);
            tick();
            gen_valid = '0;
            conf_xfer_limit = 32'd7;
            mid();
            chk("v_her_valid", her_valid, 1);
            chk("v_msgid", her_msgid, vecs[i].msgid);
            chk("v_eom", her_is_eom, vecs[i].eom);
            chk("v_ctx", her_ctx_id, vecs[i].exp_ctx);
            chk("v_addr", her_addr, 32'h8000_0000 + 32'(i) * 32'h100);
            chk("v_size", her_size, {12'h0, vecs[i].len});
            chk("v_xfer", her_xfer_size, vecs[i].exp_xfer);
            chk("v_meta", her_meta, meta_of(int'(vecs[i].exp_ctx)));
            her_ready = 1'b1;
            tick();
            her_ready = 1'b0;
        end
        conf_xfer_limit = '0;

        // Fill the queue with her_ready low; the fifth completion must wait
        for (int i = 0; i < 4; i++) begin
            drive_ch(0, 32'h4000 + 32'(i), 20'd8, mk_tag(10'h40 + 10'(i), 1'b0, 2'd1));
            gen_valid = 2'b01;
            mid();
            chk("fill_ready", gen_ready, 2'b01);
            tick();
        end
        drive_ch(0, 32'h4004, 20'd8, mk_tag(10'h44, 1'b0, 2'd1));
        for (int h = 0; h < 2; h++) begin
            mid();
            chk("full_ready", gen_ready, 2'b00);
            chk("stall_head", her_msgid, 10'h40);
            tick();
        end
        her_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            mid();
            chk("drain_valid", her_valid, 1);
            chk("drain_order", her_msgid, 10'h40 + 10'(j));
            if (j == 0) chk("no_push_through", gen_ready, 2'b00);
            if (j == 1) chk("fifth_accept", gen_ready, 2'b01);
            tick();
            if (j == 1) gen_valid = '0;
        end
        mid();
        chk("drain_empty", her_valid, 0);
        tick();
        her_ready = 1'b0;

        // Enabling ctx3 in the same cycle as a ctx3 completion still falls back to ctx0
        conf(3, 1'b1);
        drive_ch(0, 32'h7700, 20'd40, mk_tag(10'h77, 1'b1, 2'd3));
        gen_valid = 2'b01;
        mid();
        chk("wr_cycle_ready", gen_ready, 2'b01);
        tick();
        conf_wr_en = 1'b0;
        gen_valid = '0;
        mid();
        chk("wr_cycle_ctx", her_ctx_id, 2'd0);
        chk("wr_cycle_meta", her_meta, meta_of(0));
        chk("wr_cycle_msgid", her_msgid, 10'h77);
        her_ready = 1'b1;
        tick();
        her_ready = 1'b0;
        drive_ch(0, 32'h7800, 20'd40, mk_tag(10'h78, 1'b0, 2'd3));
        gen_valid = 2'b01;
        tick();
        gen_valid = '0;
        mid();
        chk("ctx3_now_on", her_ctx_id, 2'd3);
        chk("ctx3_meta", her_meta, meta_of(3));
        her_ready = 1'b1;
        tick();
        her_ready = 1'b0;

`ifdef PSPIN_HER_GEN_STATS_EN
        exp_cnt = '{32'd4, 32'd9, 32'd4, 32'd1};
        exp_fb  = 32'd2;
`else
        exp_cnt = '{32'd0, 32'd0, 32'd0, 32'd0};
        exp_fb  = 32'd0;
`endif
        mid();
        for (int k = 0; k < NCTX; k++) chk("stat_her_cnt", stat_her_cnt[k*32 +: 32], exp_cnt[k]);
        chk("stat_fallback", stat_fallback_cnt, exp_fb);
        tick();

        // Disable ctx0 while one HER is queued: intake stops, queue still drains
        conf(0, 1'b0);
        drive_ch(0, 32'h5500, 20'd12, mk_tag(10'h55, 1'b1, 2'd0));
        gen_valid = 2'b01;
        mid();
        chk("dis_cycle_ready", gen_ready, 2'b01);
        tick();
        conf_wr_en = 1'b0;
        gen_valid = 2'b11;
        mid();
        chk("ctx0_dis_ready", gen_ready, 2'b00);
        chk("dis_queued_valid", her_valid, 1);
        chk("dis_queued_msgid", her_msgid, 10'h55);
        chk("dis_queued_ctx", her_ctx_id, 2'd0);
        her_ready = 1'b1;
        tick();
        her_ready = 1'b0;
        mid();
        chk("dis_drained", her_valid, 0);
        chk("dis_ready_still", gen_ready, 2'b00);
        tick();

        // Reset with three HERs queued: none may be emitted afterwards
        gen_valid = '0;
        conf(0, 1'b1);
        tick();
        conf_wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_ch(0, 32'h6000 + 32'(i), 20'd4, mk_tag(10'h60 + 10'(i), 1'b0, 2'd1));
            gen_valid = 2'b01;
            tick();
        end
        gen_valid = '0;
        mid();
        chk("pre_rst_valid", her_valid, 1);
        chk("pre_rst_head", her_msgid, 10'h60);
        tick();
        rstn = 1'b0;
        gen_valid = 2'b01;
        mid();
        chk("in_rst_ready", gen_ready, 2'b00);
        chk("in_rst_valid", her_valid, 0);
        tick();
        rstn = 1'b1;
        her_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk("post_rst_empty", her_valid, 0);
            chk("post_rst_ready", gen_ready, 2'b00);
            tick();
        end
        mid();
        chk("post_rst_fallback", stat_fallback_cnt, 0);
        chk("post_rst_her_cnt", stat_her_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
